// File: rtl/mem_block_reader.sv
// Streams a contiguous, wrap-around address range out of a 1-cycle-latency RAM as valid/ready.
// Define MEM_BLOCK_READER_STALL_CNT_EN to add the stall_cnt output.
module mem_block_reader #(
  parameter int unsigned DATAW = 128,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   length,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             o_valid,
  output logic [DATAW-1:0] o_data,
  output logic             o_last,
`ifdef MEM_BLOCK_READER_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
`endif
  input  logic             o_ready
);

  localparam logic [ADDRW-1:0] AddrMax = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW-1:0] AddrOne = ADDRW'(1);
  localparam logic [ADDRW:0]   CntOne  = (ADDRW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   rem_issue_q, rem_issue_d;
  logic [ADDRW:0]   rem_send_q, rem_send_d;
  logic             inflight_q;
  logic             done_q, done_d;
  logic [DATAW-1:0] slot_q [2];
  logic [DATAW-1:0] slot_d [2];
  logic [1:0]       cnt_q, cnt_d;
  logic [2:0]       level;
  logic             pop, issue, accept;

  assign o_valid   = (cnt_q != 2'd0);
  assign o_data    = slot_q[0];
  assign o_last    = o_valid && (rem_send_q == CntOne);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign mem_raddr = addr_q;
  assign pop       = o_valid && o_ready;
  assign accept    = (state_q == StIdle) && start;

  // Words already buffered or on their way must fit in the 2 slots once this issue lands.
  always_comb begin
    level = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == StRun) && (rem_issue_q != '0) && (level < 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_issue_d = rem_issue_q;
    rem_send_d  = pop ? rem_send_q - CntOne : rem_send_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length != '0) begin
            state_d     = StRun;
            addr_d      = base_addr;
            rem_issue_d = length;
            rem_send_d  = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = (addr_q == AddrMax) ? '0 : addr_q + AddrOne;
          rem_issue_d = rem_issue_q - CntOne;
          if (rem_issue_q == CntOne) state_d = StFlush;
        end
      end
      StFlush: begin
        if (pop && (rem_send_q == CntOne)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot 0 is the head; a push lands in the first slot left free after this cycle's pop.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (pop) slot_d[0] = slot_q[1];
    if (inflight_q) begin
      if ((cnt_q - {1'b0, pop}) == 2'd0) slot_d[0] = mem_rdata;
      else                               slot_d[1] = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_send_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      slot_q[0]   <= '0;
      slot_q[1]   <= '0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_send_q  <= rem_send_d;
      inflight_q  <= issue;
      done_q      <= done_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef MEM_BLOCK_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if (busy && o_valid && !o_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_reader.sv
// Self-checking bench for mem_block_reader: vector table, hand-written corner cases and
// randomized transfers checked against an address-arithmetic reference model.
module tb_mem_block_reader;

  localparam int DATAW = 128;
  localparam int DEPTH = 64;
  localparam int ADDRW = 6;

  logic             clk;
  logic             rst;
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [ADDRW:0]   length;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic             o_valid;
  logic [DATAW-1:0] o_data;
  logic             o_last;
  logic             o_ready;
`ifdef MEM_BLOCK_READER_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATAW-1:0] mem [DEPTH];

  mem_block_reader #(
    .DATAW(DATAW),
    .DEPTH(DEPTH),
    .ADDRW(ADDRW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_last(o_last),
`ifdef MEM_BLOCK_READER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .o_ready(o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency RAM model.
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  function automatic logic [DATAW-1:0] word_at(input int a);
    return {4{32'hC0DE_0000 + 32'(a)}};
  endfunction

  task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer in the current cycle and checks it through the done cycle.
  // Returns in the done cycle, so a following call exercises a back-to-back start.
  task automatic run_xfer(input int base, input int len, input bit rnd, input int poke,
                          output int beats, output int last_addr);
    int idx, cyc, stalls;
    bit was_stall;
    logic [DATAW-1:0] held;
    start = 1'b1; base_addr = ADDRW'(base); length = (ADDRW + 1)'(len); o_ready = 1'b1;
    step;
    start = 1'b0;
    chk("busy_t1", busy, 1);
    chk("raddr_t1", mem_raddr, base);
    idx = 0; cyc = 0; stalls = 0; was_stall = 0; beats = 0; last_addr = -1; held = '0;
    while (idx < len && cyc < 1000) begin
      if (cyc == poke) begin
        start = 1'b1; base_addr = '0; length = 7'd3;
      end else begin
        start = 1'b0;
      end
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("busy_run", busy, 1);
      if (was_stall) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, held);
      end
      chk("last_flag", o_last, o_valid && (idx == len - 1));
      if (o_valid && o_ready) begin
        chk("data", o_data, word_at((base + idx) % DEPTH));
        last_addr = int'(o_data[31:0] - 32'hC0DE_0000);
        beats++;
        idx++;
      end
      if (o_valid && !o_ready) stalls++;
      was_stall = o_valid && !o_ready;
      held = o_data;
      step;
      cyc++;
    end
    start = 1'b0;
    o_ready = 1'b1;
    if (idx < len) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d beats required %0d", idx, len);
    end
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", o_valid, 0);
`ifdef MEM_BLOCK_READER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
  endtask

  typedef struct {
    int base;
    int len;
    bit rnd;
    int exp_beats;
    int exp_last;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int b, la, k, rb, rl;

    for (int i = 0; i < DEPTH; i++) mem[i] = word_at(i);
    vecs[0] = '{5, 4, 1'b0, 4, 8};
    vecs[1] = '{62, 4, 1'b0, 4, 1};
    vecs[2] = '{0, 64, 1'b0, 64, 63};
    vecs[3] = '{10, 8, 1'b1, 8, 17};
    vecs[4] = '{60, 8, 1'b1, 8, 3};
    vecs[5] = '{0, 1, 1'b0, 1, 0};
    vecs[6] = '{63, 64, 1'b1, 64, 62};

    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0; o_ready = 1'b0;
    step; step; step;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_raddr", mem_raddr, 0);
    rst = 1'b1;
    step;

    // Exact cycle timing: base 5, length 4, consumer always ready.
    start = 1'b1; base_addr = 6'd5; length = 7'd4; o_ready = 1'b1;
    step;
    start = 1'b0;
    chk("s1_busy_t1", busy, 1);
    chk("s1_raddr_t1", mem_raddr, 5);
    step;
    chk("s1_valid_t2", o_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("s1_valid", o_valid, 1);
      chk("s1_data", o_data, word_at(5 + i));
      chk("s1_last", o_last, i == 3);
      chk("s1_busy", busy, 1);
    end
    step;
    chk("s1_done", done, 1);
    chk("s1_busy_end", busy, 0);
    step;
    chk("s1_done_once", done, 0);

    // Address wrap from 63 to 0.
    start = 1'b1; base_addr = 6'd62; length = 7'd4;
    step;
    start = 1'b0;
    chk("wrap_raddr0", mem_raddr, 62);
    step;
    chk("wrap_raddr1", mem_raddr, 63);
    step;
    chk("wrap_raddr2", mem_raddr, 0);
    k = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (o_valid) begin
        chk("wrap_data", o_data, word_at((62 + k) % DEPTH));
        k++;
      end
      step;
    end
    chk("wrap_beats", k, 4);
    chk("wrap_done", done, 1);
    step;

    // Zero length: done next cycle, nothing else moves.
    start = 1'b1; base_addr = 6'd9; length = 7'd0;
    step;
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", o_valid, 0);
    step;
    chk("zero_done_once", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_valid2", o_valid, 0);

    // Start pulsed mid-transfer must be ignored.
    run_xfer(20, 6, 1'b0, 1, b, la);
    chk("poke_beats", b, 6);
    chk("poke_last", la, 25);
    step;

    // Vector table; each row starts in the previous row's done cycle.
    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].rnd, -1, b, la);
      chk("vec_beats", b, vecs[i].exp_beats);
      chk("vec_last", la, vecs[i].exp_last);
    end
    step;

    // Reset with both buffer slots full.
    start = 1'b1; base_addr = 6'd30; length = 7'd8; o_ready = 1'b0;
    step;
    start = 1'b0;
    step; step; step;
    chk("mrst_pre_valid", o_valid, 1);
    chk("mrst_pre_data", o_data, word_at(30));
    rst = 1'b0;
    step;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_raddr", mem_raddr, 0);
    rst = 1'b1; o_ready = 1'b1;
    step;
    chk("mrst_done2", done, 0);
    chk("mrst_valid2", o_valid, 0);
    chk("mrst_busy2", busy, 0);
    step;
    run_xfer(5, 4, 1'b0, -1, b, la);
    chk("mrst_beats", b, 4);
    chk("mrst_last", la, 8);

    // Randomized transfers against the address-arithmetic model.
    for (int i = 0; i < 12; i++) begin
      rb = int'($urandom_range(0, DEPTH - 1));
      rl = int'($urandom_range(1, DEPTH));
      run_xfer(rb, rl, 1'b1, -1, b, la);
      chk("rnd_beats", b, rl);
      chk("rnd_last", la, (rb + rl - 1) % DEPTH);
      if (($urandom_range(0, 1)) == 1) step;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_block_reader.md
# mem_block_reader

Sequential read engine for `memory_block`, the synchronous single-write/single-read RAM with one-cycle read latency. On a start command it walks a contiguous, wrap-around range of addresses and presents each word as a valid/ready output stream. Backpressure is absorbed by a 2-entry output buffer, so a stalled consumer never loses data. It sits between a weight/activation buffer and the MLP datapath or controller that consumes rows.

## Interface
- `DATAW`, 128, word width; must equal the attached `memory_block` DATAW.
- `DEPTH`, 64, number of words in the attached memory.
- `ADDRW`, `$clog2(DEPTH)`, address width.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle command strobe; sampled only in IDLE.
- `base_addr` input ADDRW: first word address; latched on accepted `start`.
- `length` input ADDRW+1: word count, 0..DEPTH; latched on accepted `start`.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle pulse at transfer completion.
- `mem_raddr` output ADDRW: registered read address to `memory_block.raddr`.
- `mem_rdata` input DATAW: from `memory_block.rdata`; valid the cycle after the address is issued.
- `o_valid` output 1: output word valid.
- `o_data` output DATAW: output word.
- `o_last` output 1: high with the final word of a transfer.
- `o_ready` input 1: consumer accepts the word when `o_valid && o_ready`.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE + `start` with `length != 0` → RUN. Latch the address counter = `base_addr`, remaining-to-issue = `length`, remaining-to-send = `length`.
- IDLE + `start` with `length == 0` → stay in IDLE. Pulse `done` next cycle; no beats; `busy` never rises.
- `start` outside IDLE is ignored; no queuing.
- RUN issue rule: issue a read in a cycle when remaining-to-issue > 0 and (buffer occupancy + in-flight − pop this cycle) < 2.
  - On issue, the address advances by 1 modulo DEPTH. DEPTH−1 wraps to 0, including non-power-of-2 DEPTH.
  - Remaining-to-issue decrements.
- One in-flight flag, delayed one cycle. When set, `mem_rdata` is written into the buffer that cycle.
- Buffer: 2-entry FIFO. Head drives `o_data`/`o_valid`. `o_last` = head is the word where remaining-to-send == 1.
- Remaining-to-issue reaching 0 → FLUSH.
- FLUSH → IDLE on the handshake of the last word; `done` pulses the following cycle.
- `o_data` stays stable while `o_valid && !o_ready`. `o_valid` never drops without a handshake.
- Reset: all outputs 0, state IDLE, counters 0, buffer and in-flight cleared. A mid-transfer reset discards the in-flight read and buffered words; no `done` is emitted.

## Timing
- `start` accepted at cycle T:
  - `busy` = 1 from T+1.
  - `mem_raddr` = `base_addr` at T+1.
  - Data arrives at T+2; `o_valid` = 1 at T+3.
- With `o_ready` held high: one word per cycle sustained, no bubbles. Word k presented at T+3+k.
- Last handshake at cycle L: `busy` = 1 through L, `done` = 1 and `busy` = 0 at L+1. A new `start` is accepted at L+1.
- Stall release: if `o_ready` is low for N cycles, at most 2 words are buffered. Issue resumes in the same cycle that a pop frees a slot.
- `mem_raddr` holds its last value when not issuing; spurious reads are harmless.

## Configuration
- `MEM_BLOCK_READER_STALL_CNT_EN` defined: adds output `stall_cnt` [31:0].
  - Clears on accepted `start` and on reset.
  - Increments each cycle `o_valid && !o_ready` while `busy`; saturates at 2^32−1.
  - Holds its value after `done`.
- Undefined: the port and the counter are absent.

## Test plan
- Preload mem[i] = i. `base_addr=5`, `length=4`, `o_ready`=1 → data 5,6,7,8 at T+3..T+6. `o_last` only on 8. `done` at T+7.
- DEPTH=64, `base_addr=62`, `length=4` → data 62,63,0,1; `mem_raddr` wraps to 0.
- `length=8`, `o_ready` toggled 1,0,0,1,… randomly → all 8 words in order with no duplicates. `o_data` stable while stalled; buffer never exceeds 2. With macro defined, `stall_cnt` equals the counted stall cycles.
- `length=0` → `done` at T+1, `o_valid` never high, `busy` never high. `start` pulsed during RUN → ignored; beat count unchanged.
- `length=64`, `base_addr=0` → 64 words, `o_last` on word 63. Back-to-back `start` in the `done` cycle is accepted.
- `rst` low for one cycle mid-transfer with 2 words buffered → next cycle `o_valid`, `busy`, `done` = 0 and state IDLE. A fresh `start` then behaves as in scenario 1.
